// File: rtl/comparador_serial_nb_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package comparador_serial_nb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Width of a counter able to hold 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/comparador_serial_nb_bit.sv
// One-bit compare cell: equality and A-greater-than-B for a single bit pair.
module comparador_bit (
    input  logic a_bit,
    input  logic b_bit,
    output logic eq,
    output logic gt
);

    // Pure combinational cell.
    always_comb begin
        eq = ~(a_bit ^ b_bit);
        gt = a_bit & ~b_bit;
    end

endmodule

// File: rtl/comparador_serial_nb.sv
// Bit-serial WIDTH-bit unsigned magnitude comparator, MSB first, with a
// start/busy/done handshake. Flags hold until the next accepted start.
module comparador_serial_nb
    import comparador_serial_nb_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter bit  EARLY_EXIT = 1'b1,
    localparam int CNT_W      = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic [CNT_W-1:0] bit_count
);

    state_t             state;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic               pend_diff;
    logic               pend_gt;

    logic               bit_eq;
    logic               bit_gt;
    logic               verdict_diff;
    logic               verdict_gt;
    logic [CNT_W-1:0]   cnt_next;
    logic               finish;
    logic               shift_en;

    comparador_bit u_bit (
        .a_bit (sh_a[WIDTH-1]),
        .b_bit (sh_b[WIDTH-1]),
        .eq    (bit_eq),
        .gt    (bit_gt)
    );

    // Fold the current MSB result into the pending verdict; the first
    // difference wins and later bits never overwrite it.
    always_comb begin
        verdict_diff = pend_diff | ~bit_eq;
        verdict_gt   = pend_diff ? pend_gt : bit_gt;
        cnt_next     = bit_count + CNT_W'(1);
        finish       = (cnt_next == CNT_W'(WIDTH)) || (EARLY_EXIT && !bit_eq);
        shift_en     = bit_eq || !EARLY_EXIT;
    end

    // FSM, shift registers, counter and registered result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            pend_diff <= 1'b0;
            pend_gt   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_eq_b    <= 1'b0;
            a_gt_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            bit_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a      <= a;
                        sh_b      <= b;
                        pend_diff <= 1'b0;
                        pend_gt   <= 1'b0;
                        a_eq_b    <= 1'b0;
                        a_gt_b    <= 1'b0;
                        a_lt_b    <= 1'b0;
                        bit_count <= '0;
                        busy      <= 1'b1;
                        state     <= S_SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    bit_count <= cnt_next;
                    pend_diff <= verdict_diff;
                    pend_gt   <= verdict_gt;
                    if (shift_en) begin
                        sh_a <= {sh_a[WIDTH-2:0], 1'b0};
                        sh_b <= {sh_b[WIDTH-2:0], 1'b0};
                    end
                    if (finish) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        a_eq_b <= ~verdict_diff;
                        a_gt_b <= verdict_diff & verdict_gt;
                        a_lt_b <= verdict_diff & ~verdict_gt;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial_nb.sv
// Scoreboard bench: two comparators (early exit on / off) share clock and
// reset; expected verdicts are queued at start and checked on done.
module tb_comparador_serial_nb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start_ee = 1'b0, start_ne = 1'b0;
    logic [7:0] a_ee = '0, b_ee = '0, a_ne = '0, b_ne = '0;
    logic       busy_ee, done_ee, eq_ee, gt_ee, lt_ee;
    logic       busy_ne, done_ne, eq_ne, gt_ne, lt_ne;
    logic [3:0] cnt_ee, cnt_ne;

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   cnt;
        int   due;
    } item_t;

    item_t q_ee[$];
    item_t q_ne[$];
    item_t it_ee, it_ne;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    comparador_serial_nb #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst(rst), .start(start_ee), .a(a_ee), .b(b_ee),
        .busy(busy_ee), .done(done_ee), .a_eq_b(eq_ee), .a_gt_b(gt_ee),
        .a_lt_b(lt_ee), .bit_count(cnt_ee)
    );

    comparador_serial_nb #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_ne (
        .clk(clk), .rst(rst), .start(start_ne), .a(a_ne), .b(b_ne),
        .busy(busy_ne), .done(done_ne), .a_eq_b(eq_ne), .a_gt_b(gt_ne),
        .a_lt_b(lt_ne), .bit_count(cnt_ne)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // 1-based position of the first differing bit from the MSB, 0 if equal.
    function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
        for (int i = 7; i >= 0; i--)
            if (x[i] != y[i]) return 8 - i;
        return 0;
    endfunction

    // Drive one start pulse; optionally queue the expected result.
    task automatic go(input bit ne, input logic [7:0] av, input logic [7:0] bv, input bit push);
        item_t it;
        int fd, k;
        @(negedge clk);
        fd = first_diff(av, bv);
        k  = (!ne && fd != 0) ? fd : 8;
        it.eq  = (av == bv);
        it.gt  = (av > bv);
        it.lt  = (av < bv);
        it.cnt = k;
        it.due = cyc + 1 + k;
        if (ne) begin
            a_ne = av; b_ne = bv; start_ne = 1'b1;
            if (push) q_ne.push_back(it);
        end else begin
            a_ee = av; b_ee = bv; start_ee = 1'b1;
            if (push) q_ee.push_back(it);
        end
        @(negedge clk);
        start_ee = 1'b0;
        start_ne = 1'b0;
    endtask

    // Wait for outstanding results, scrambling operand inputs meanwhile.
    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (q_ee.size() == 0 && q_ne.size() == 0) break;
            a_ee = 8'($urandom); b_ee = 8'($urandom);
            a_ne = 8'($urandom); b_ne = 8'($urandom);
            @(negedge clk);
        end
        if (q_ee.size() != 0 || q_ne.size() != 0) begin
            check("timeout_pending", q_ee.size() + q_ne.size(), 0);
            q_ee.delete();
            q_ne.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done_ee) begin
            if (q_ee.size() == 0) check("ee_spurious_done", 1, 0);
            else begin
                it_ee = q_ee.pop_front();
                check("ee_flags", {eq_ee, gt_ee, lt_ee}, {it_ee.eq, it_ee.gt, it_ee.lt});
                check("ee_bit_count", cnt_ee, it_ee.cnt);
                check("ee_done_cycle", cyc, it_ee.due);
                check("ee_busy_at_done", busy_ee, 0);
            end
        end
        if (done_ne) begin
            if (q_ne.size() == 0) check("ne_spurious_done", 1, 0);
            else begin
                it_ne = q_ne.pop_front();
                check("ne_flags", {eq_ne, gt_ne, lt_ne}, {it_ne.eq, it_ne.gt, it_ne.lt});
                check("ne_bit_count", cnt_ne, it_ne.cnt);
                check("ne_done_cycle", cyc, it_ne.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ee", {busy_ee, done_ee, eq_ee, gt_ee, lt_ee, cnt_ee}, '0);
        check("reset_ne", {busy_ne, done_ne, eq_ne, gt_ne, lt_ne, cnt_ne}, '0);
        rst = 1'b0;

        // Equal operands, first-bit difference, last-bit difference.
        go(0, 8'hA5, 8'hA5, 1);
        check("busy_after_start", busy_ee, 1);
        wait_idle();
        check("flags_hold_eq", {eq_ee, gt_ee, lt_ee}, 3'b100);
        go(0, 8'h80, 8'h7F, 1); wait_idle();
        go(0, 8'h10, 8'h11, 1); wait_idle();
        go(0, 8'h00, 8'hFF, 1); wait_idle();
        go(0, 8'hFF, 8'hFE, 1); wait_idle();

        // Full scan with a first-bit difference; a start while busy is ignored.
        go(1, 8'h80, 8'h00, 1);
        repeat (3) @(negedge clk);
        a_ne = 8'h00; b_ne = 8'hFF; start_ne = 1'b1;
        @(negedge clk);
        check("ne_busy_ignore_start", busy_ne, 1);
        start_ne = 1'b0;
        wait_idle();
        check("ne_single_done", q_ne.size(), 0);

        // Reset mid-comparison discards the run without a done pulse.
        go(0, 8'hA5, 8'hA5, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_run", {busy_ee, done_ee, eq_ee, gt_ee, lt_ee, cnt_ee}, '0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        go(0, 8'h01, 8'h02, 1); wait_idle();

        // Back-to-back: start held during the done cycle.
        go(0, 8'h80, 8'h7F, 1);
        @(negedge clk);
        check("b2b_done_seen", done_ee, 1);
        a_ee = 8'h3C; b_ee = 8'h3C; start_ee = 1'b1;
        q_ee.push_back('{eq: 1'b1, gt: 1'b0, lt: 1'b0, cnt: 8, due: cyc + 9});
        @(negedge clk);
        start_ee = 1'b0;
        check("b2b_restart", {busy_ee, done_ee, eq_ee, gt_ee, lt_ee, cnt_ee}, {1'b1, 8'h00});
        wait_idle();

        // Random operands on both variants.
        for (int i = 0; i < 6; i++) begin
            go(0, 8'($urandom), 8'($urandom), 1);
            wait_idle();
        end
        for (int i = 0; i < 4; i++) begin
            go(1, 8'($urandom), 8'($urandom), 1);
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
